// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller.
// Holds the geometry parameters, the controller state encoding and the
// helpers that split a fetch address into word / index / tag fields.
package icache_pkg;

  localparam int LINE_WORDS = 8;   // 32-bit words per line
  localparam int IDX_W      = 11;  // line index width (2048 lines)
  localparam int TAG_W      = 16;  // tag = addr[31:16]
  localparam int OFF_W      = 5;   // byte offset within a 256-bit line
  localparam int WORD_W     = 3;   // word select within a line

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MREQ   = 3'd2,
    MRSP   = 3'd3,
    WRITE  = 3'd4,
    RESP   = 3'd5
  } state_t;

  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return a[4:2];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[15:5];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:16];
  endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Line refill buffer: collects eight 32-bit beats in ascending word order.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   beat_en_i      a beat is present this cycle (already qualified by FSM)
//   beat_data_i    beat payload
//   line_o         assembled 256-bit line, word 0 in bits [31:0]
//   done_o         high in the cycle the last (8th) beat is accepted
module icache_refill_buf
  import icache_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         beat_en_i,
  input  logic [31:0]  beat_data_i,
  output logic [255:0] line_o,
  output logic         done_o
);

  logic [WORD_W-1:0] cnt_q;
  logic [255:0]      buf_q;

  // The counter wraps from 7 back to 0, so each refill starts at slot 0
  // without an explicit clear; reset discards any partial refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else if (beat_en_i) begin
      buf_q[{cnt_q, 5'b0} +: 32] <= beat_data_i;
      cnt_q                      <= cnt_q + 3'd1;
    end
  end

  assign done_o = beat_en_i && (cnt_q == 3'd7);
  assign line_o = buf_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller (2048 lines x 256 bits).
// Hits answer one cycle after accept; misses refill the line over the
// memory bus in eight beats, write data + tag through SRAM port 0 and then
// answer from the refill buffer.
// Ports:
//   clock, reset                   clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request handshake
//   flush                          invalidate all lines (honoured in IDLE)
//   rsp_valid/rsp_data             one-cycle response pulse + word
//   dsram_*1 / tsram_*1            data / tag SRAM read port (active-low csb)
//   dsram_*0 / tsram_*0            data / tag SRAM write port
//   mem_req_*                      line refill request (line-aligned address)
//   mem_rsp_valid/mem_rsp_data     refill beats, no back-pressure
//   dbg_state                      current controller state
// Handshake: a transfer happens in a cycle where both valid and ready are
// high; a valid, once raised, holds its payload stable until that cycle.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         flush,
  output logic         rsp_valid,
  output logic [31:0]  rsp_data,
  output logic         dsram_csb1,
  output logic [10:0]  dsram_addr1,
  input  logic [255:0] dsram_dout1,
  output logic         dsram_csb0,
  output logic         dsram_web0,
  output logic [31:0]  dsram_wmask0,
  output logic [10:0]  dsram_addr0,
  output logic [255:0] dsram_din0,
  output logic         tsram_csb1,
  output logic [10:0]  tsram_addr1,
  input  logic [31:0]  tsram_dout1,
  output logic         tsram_csb0,
  output logic         tsram_web0,
  output logic [3:0]   tsram_wmask0,
  output logic [10:0]  tsram_addr0,
  output logic [31:0]  tsram_din0,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_rsp_valid,
  input  logic [31:0]  mem_rsp_data,
  output logic [2:0]   dbg_state
);

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [2047:0] valid_q;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] word_q;
  logic              in_idle, accept, flush_acc, hit;
  logic              beat_en, refill_done;
  logic [255:0]      line_buf;
  logic              unused_bits;

  assign idx_q  = addr_idx(addr_q);
  assign tag_q  = addr_tag(addr_q);
  assign word_q = addr_word(addr_q);

  // Flush has priority over a simultaneous fetch; neither is taken in reset.
  assign in_idle   = (state_q == IDLE) && !reset;
  assign flush_acc = in_idle && flush;
  assign accept    = in_idle && req_valid && !flush;
  assign hit       = valid_q[idx_q] && (tsram_dout1[15:0] == tag_q);
  assign beat_en   = (state_q == MRSP) && mem_rsp_valid;

  assign unused_bits = ^{tsram_dout1[31:16], addr_q[1:0]};
  assign dbg_state   = state_q;

  icache_refill_buf u_refill_buf (
    .clk_i       (clock),
    .rst_i       (reset),
    .beat_en_i   (beat_en),
    .beat_data_i (mem_rsp_data),
    .line_o      (line_buf),
    .done_o      (refill_done)
  );

  // State register, fetch address and valid vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (flush_acc) begin
        valid_q <= '0;
      end else if (state_q == WRITE) begin
        valid_q[idx_q] <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    addr_d  = accept ? req_addr : addr_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : MREQ;
      MREQ:    if (mem_req_ready) state_d = MRSP;
      MRSP:    if (refill_done) state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is held at its idle value while in reset.
  always_comb begin
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    dsram_csb1    = 1'b1;
    dsram_addr1   = '0;
    tsram_csb1    = 1'b1;
    tsram_addr1   = '0;
    dsram_csb0    = 1'b1;
    dsram_web0    = 1'b1;
    dsram_wmask0  = '0;
    dsram_addr0   = '0;
    dsram_din0    = '0;
    tsram_csb0    = 1'b1;
    tsram_web0    = 1'b1;
    tsram_wmask0  = '0;
    tsram_addr0   = '0;
    tsram_din0    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (accept) begin
            dsram_csb1  = 1'b0;
            dsram_addr1 = addr_idx(req_addr);
            tsram_csb1  = 1'b0;
            tsram_addr1 = addr_idx(req_addr);
          end
        end
        LOOKUP: begin
          if (hit) begin
            rsp_valid = 1'b1;
            rsp_data  = dsram_dout1[{word_q, 5'b0} +: 32];
          end
        end
        MREQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {addr_q[31:5], 5'b0};
        end
        WRITE: begin
          dsram_csb0   = 1'b0;
          dsram_web0   = 1'b0;
          dsram_wmask0 = '1;
          dsram_addr0  = idx_q;
          dsram_din0   = line_buf;
          tsram_csb0   = 1'b0;
          tsram_web0   = 1'b0;
          tsram_wmask0 = '1;
          tsram_addr0  = idx_q;
          tsram_din0   = {16'b0, tag_q};
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_data  = line_buf[{word_q, 5'b0} +: 32];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         flush = 1'b0;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         dsram_csb1;
  logic [10:0]  dsram_addr1;
  logic [255:0] dsram_dout1 = '0;
  logic         dsram_csb0, dsram_web0;
  logic [31:0]  dsram_wmask0;
  logic [10:0]  dsram_addr0;
  logic [255:0] dsram_din0;
  logic         tsram_csb1;
  logic [10:0]  tsram_addr1;
  logic [31:0]  tsram_dout1 = '0;
  logic         tsram_csb0, tsram_web0;
  logic [3:0]   tsram_wmask0;
  logic [10:0]  tsram_addr0;
  logic [31:0]  tsram_din0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [31:0]  mem_rsp_data = '0;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dwrites = 0;
  int twrites = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  icache_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dsram_csb1(dsram_csb1), .dsram_addr1(dsram_addr1), .dsram_dout1(dsram_dout1),
    .dsram_csb0(dsram_csb0), .dsram_web0(dsram_web0), .dsram_wmask0(dsram_wmask0),
    .dsram_addr0(dsram_addr0), .dsram_din0(dsram_din0),
    .tsram_csb1(tsram_csb1), .tsram_addr1(tsram_addr1), .tsram_dout1(tsram_dout1),
    .tsram_csb0(tsram_csb0), .tsram_web0(tsram_web0), .tsram_wmask0(tsram_wmask0),
    .tsram_addr0(tsram_addr0), .tsram_din0(tsram_din0),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .dbg_state(dbg_state)
  );

  // ---------------- SRAM macro models ----------------
  logic [255:0] dmem [0:2047];
  logic [31:0]  tmem [0:2047];
  logic [255:0] dtmp;
  logic [31:0]  ttmp;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      dmem[i] = '0;
      tmem[i] = '0;
    end
  end

  always @(posedge clock) begin
    if (!dsram_csb1) dsram_dout1 <= dmem[dsram_addr1];
    if (!tsram_csb1) tsram_dout1 <= tmem[tsram_addr1];
    if (!dsram_csb0 && !dsram_web0) begin
      dtmp = dmem[dsram_addr0];
      for (int b = 0; b < 32; b++)
        if (dsram_wmask0[b]) dtmp[b*8 +: 8] = dsram_din0[b*8 +: 8];
      dmem[dsram_addr0] <= dtmp;
      dwrites <= dwrites + 1;
    end
    if (!tsram_csb0 && !tsram_web0) begin
      ttmp = tmem[tsram_addr0];
      for (int b = 0; b < 4; b++)
        if (tsram_wmask0[b]) ttmp[b*8 +: 8] = tsram_din0[b*8 +: 8];
      tmem[tsram_addr0] <= ttmp;
      twrites <= twrites + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one fetch through a full miss/refill, answering the memory request
  // with beats base, base+1, ... base+7. Reports what was observed.
  task automatic refill(input logic [31:0] a, input logic [31:0] base,
                        output bit seen_req, output logic [31:0] maddr,
                        output bit seen_rsp, output logic [31:0] rdata,
                        output int lat);
    int b7_cyc;
    seen_req = 0; seen_rsp = 0; maddr = '0; rdata = '0; lat = -1;
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4 && !seen_req; i++) begin
      if (mem_req_valid) seen_req = 1;
      else step();
    end
    if (!seen_req) begin
      step();
      return;
    end
    maddr = mem_req_addr;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    b7_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + i;
      b7_cyc = cyc;
      step();
    end
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4 && !seen_rsp; i++) begin
      if (rsp_valid) begin
        seen_rsp = 1;
        rdata    = rsp_data;
        lat      = cyc - b7_cyc;
      end
      step();
    end
  endtask

  // ---------------- test scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b rsp_valid=%b mem_req_valid=%b, required 0/0/0",
               req_ready, rsp_valid, mem_req_valid);
    end
    checks++;
    if ({dsram_csb0, dsram_web0, dsram_csb1, tsram_csb0, tsram_web0, tsram_csb1} !== 6'b111111 ||
        dsram_wmask0 !== 32'h0 || tsram_wmask0 !== 4'h0 ||
        dsram_addr0 !== 11'h0 || dsram_din0 !== 256'h0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_sram: csb/web=%b wmask=%h/%h addr0=%h mem_addr=%h, required all idle",
               {dsram_csb0, dsram_web0, dsram_csb1, tsram_csb0, tsram_web0, tsram_csb1},
               dsram_wmask0, tsram_wmask0, dsram_addr0, mem_req_addr);
    end
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_cold_miss();
    bit sq, sr; logic [31:0] ma, rd; int lat;
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'hA0 + i;
    refill(32'h0000_1004, 32'hA0, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || ma !== 32'h0000_1000) begin
      errors++;
      $display("FAIL cold_mem_addr: seen=%0d addr=%h, required 1 / 00001000", sq, ma);
    end
    checks++;
    if (!sr || rd !== 32'hA1 || lat != 2) begin
      errors++;
      $display("FAIL cold_rsp: seen=%0d data=%h lat=%0d, required 1 / a1 / 2", sr, rd, lat);
    end
    checks++;
    if (dmem[11'h080] !== exp_line || tmem[11'h080] !== 32'h0) begin
      errors++;
      $display("FAIL cold_sram: line=%h tag=%h, required %h / 0", dmem[11'h080], tmem[11'h080], exp_line);
    end
  endtask

  task automatic test_hit();
    // 0x101C then back-to-back 0x1000: each answered one cycle after accept.
    logic [31:0] addrs [0:1];
    logic [31:0] exps  [0:1];
    addrs[0] = 32'h0000_101C; exps[0] = 32'hA7;
    addrs[1] = 32'h0000_1000; exps[1] = 32'hA0;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1;
      req_addr  = addrs[k];
      step();
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exps[k] || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_%0d: rsp_valid=%b data=%h mem_req_valid=%b, required 1 / %h / 0",
                 k, rsp_valid, rsp_data, mem_req_valid, exps[k]);
      end
      step();
      checks++;
      if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_idle_%0d: ready=%b mem_req_valid=%b, required 1 / 0",
                 k, req_ready, mem_req_valid);
      end
    end
  endtask

  task automatic test_conflict();
    bit sq, sr; logic [31:0] ma, rd; int lat;
    refill(32'h0001_1000, 32'hB0, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || ma !== 32'h0001_1000 || rd !== 32'hB0 || tmem[11'h080] !== 32'h1) begin
      errors++;
      $display("FAIL conflict_fill: seen=%0d addr=%h data=%h tag=%h, required 1 / 00011000 / b0 / 1",
               sq, ma, rd, tmem[11'h080]);
    end
    refill(32'h0000_1000, 32'hC0, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || rd !== 32'hC0) begin
      errors++;
      $display("FAIL conflict_refetch: seen=%0d data=%h, required 1 / c0", sq, rd);
    end
  endtask

  task automatic test_flush();
    bit sq, sr; logic [31:0] ma, rd; int lat;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    #1;
    checks++;
    if (dsram_csb1 !== 1'b1 || tsram_csb1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_noaccept: csb1=%b/%b, required 1/1", dsram_csb1, tsram_csb1);
    end
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (dbg_state !== 3'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: state=%0d rsp_valid=%b, required 0 / 0", dbg_state, rsp_valid);
    end
    refill(32'h0000_1000, 32'hD0, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || rd !== 32'hD0) begin
      errors++;
      $display("FAIL flush_refetch: seen=%0d data=%h, required 1 / d0", sq, rd);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    int bad;
    req_valid = 1'b1;
    req_addr  = 32'h0000_2008;
    step();
    req_valid = 1'b0;
    step();  // now in MREQ
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_0000 + i;
      #1;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hE0 + i;
      step();
    end
    mem_rsp_valid = 1'b0;
    step();  // RESP
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hE2) begin
      errors++;
      $display("FAIL bp_rsp: rsp_valid=%b data=%h, required 1 / e2", rsp_valid, rsp_data);
    end
    step();
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    step();
    req_valid = 1'b0;
    got = rsp_valid;
    checks++;
    if (!got || rsp_data !== 32'hE0) begin
      errors++;
      $display("FAIL bp_word0: rsp_valid=%b data=%h, required 1 / e0", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit sq, sr; logic [31:0] ma, rd; int lat;
    int dw0, tw0;
    dw0 = dwrites; tw0 = twrites;
    req_valid = 1'b1;
    req_addr  = 32'h0000_3000;
    step();
    req_valid = 1'b0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h50 + i;
      step();
    end
    mem_rsp_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_in_reset: ready=%b, required 0", req_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (dwrites != dw0 || twrites != tw0) begin
      errors++;
      $display("FAIL midrst_nowrite: writes=%0d/%0d, required %0d/%0d", dwrites, twrites, dw0, tw0);
    end
    checks++;
    if (req_ready !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midrst_idle: ready=%b state=%0d, required 1 / 0", req_ready, dbg_state);
    end
    refill(32'h0000_3000, 32'hF0, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || rd !== 32'hF0) begin
      errors++;
      $display("FAIL midrst_refetch: seen=%0d data=%h, required 1 / f0", sq, rd);
    end
    refill(32'h0000_2000, 32'h70, sq, ma, sr, rd, lat);
    checks++;
    if (!sq || rd !== 32'h70) begin
      errors++;
      $display("FAIL midrst_invalid: seen=%0d data=%h, required 1 / 70", sq, rd);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
